// File: rtl/mem_bus_arbiter.sv
// N-channel valid/ready arbiter in front of a single memory slave, one transaction outstanding.
// Define MEM_BUS_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module mem_bus_arbiter #(
    parameter int NCH = 2,
    parameter int AW  = 32,
    parameter int DW  = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [NCH-1:0]        m_req_valid,
    output logic [NCH-1:0]        m_req_ready,
    input  logic [NCH*AW-1:0]     m_addr,
    input  logic [NCH-1:0]        m_wen,
    input  logic [NCH*DW-1:0]     m_wdata,
    input  logic [NCH*DW/8-1:0]   m_wmask,
    output logic [NCH-1:0]        m_resp_valid,
    input  logic [NCH-1:0]        m_resp_ready,
    output logic [DW-1:0]         m_rdata,
    output logic                  m_rerr,
    output logic                  s_req_valid,
    input  logic                  s_req_ready,
    output logic [AW-1:0]         s_addr,
    output logic                  s_wen,
    output logic [DW-1:0]         s_wdata,
    output logic [DW/8-1:0]       s_wmask,
    input  logic                  s_resp_valid,
    output logic                  s_resp_ready,
    input  logic [DW-1:0]         s_rdata,
    input  logic                  s_rerr,
    output logic [NCH-1:0]        grant
);

    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int MW = DW / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [NCH-1:0] r_grant;
    logic [NCH-1:0] w_grant_nxt;
    logic [IW-1:0]  w_win;
    logic           w_found;
    logic           w_resp_hs;
    logic [IW-1:0]  w_ptr_adv;

    function automatic logic [NCH-1:0] onehot(input logic [IW-1:0] idx);
        return NCH'(1'b1) << idx;
    endfunction

`ifdef MEM_BUS_ARB_RR_EN
    logic [IW-1:0]  r_ptr;
    logic [IW-1:0]  w_ptr_nxt;

    // Round-robin winner: channels at or above the pointer first, then wrap around.
    always_comb begin
        w_win   = '0;
        w_found = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (!w_found && m_req_valid[i] && (IW'(i) >= r_ptr)) begin
                w_win   = IW'(i);
                w_found = 1'b1;
            end else begin
                w_found = w_found;
            end
        end
        for (int i = 0; i < NCH; i++) begin
            if (!w_found && m_req_valid[i]) begin
                w_win   = IW'(i);
                w_found = 1'b1;
            end else begin
                w_found = w_found;
            end
        end
    end
`else
    // Fixed-priority winner: lowest requesting index.
    always_comb begin
        w_win   = '0;
        w_found = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (!w_found && m_req_valid[i]) begin
                w_win   = IW'(i);
                w_found = 1'b1;
            end else begin
                w_found = w_found;
            end
        end
    end
`endif

    // Pointer value following the currently granted channel, wrapping at NCH.
    always_comb begin
        w_ptr_adv = '0;
        for (int i = 0; i < NCH; i++) begin
            if (r_grant[i]) begin
                w_ptr_adv = IW'((i + 1) % NCH);
            end else begin
                w_ptr_adv = w_ptr_adv;
            end
        end
    end

    assign w_resp_hs = (r_state == ST_RESP) && s_resp_valid && (|(r_grant & m_resp_ready));

    // Next-state logic; the grant is locked from acceptance to the response handshake.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
`ifdef MEM_BUS_ARB_RR_EN
        w_ptr_nxt   = r_ptr;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_REQ;
                    w_grant_nxt = onehot(w_win);
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (s_req_ready) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_RESP: begin
                if (w_resp_hs) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = '0;
`ifdef MEM_BUS_ARB_RR_EN
                    w_ptr_nxt   = w_ptr_adv;
`endif
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    // State, grant and pointer registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
`ifdef MEM_BUS_ARB_RR_EN
            r_ptr   <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
`ifdef MEM_BUS_ARB_RR_EN
            r_ptr   <= w_ptr_nxt;
`endif
        end
    end

    // Handshake pass-through and AND-OR mux of the granted channel; all zero without a grant.
    always_comb begin
        m_req_ready  = '0;
        m_resp_valid = '0;
        m_rdata      = '0;
        m_rerr       = 1'b0;
        s_req_valid  = 1'b0;
        s_resp_ready = 1'b0;
        s_addr       = '0;
        s_wen        = 1'b0;
        s_wdata      = '0;
        s_wmask      = '0;
        for (int i = 0; i < NCH; i++) begin
            s_addr  = s_addr  | (m_addr[i*AW +: AW]  & {AW{r_grant[i]}});
            s_wen   = s_wen   | (m_wen[i]            & r_grant[i]);
            s_wdata = s_wdata | (m_wdata[i*DW +: DW] & {DW{r_grant[i]}});
            s_wmask = s_wmask | (m_wmask[i*MW +: MW] & {MW{r_grant[i]}});
        end
        if (r_state == ST_REQ) begin
            s_req_valid = 1'b1;
            m_req_ready = r_grant & {NCH{s_req_ready}};
        end else if (r_state == ST_RESP) begin
            m_resp_valid = r_grant & {NCH{s_resp_valid}};
            s_resp_ready = |(r_grant & m_resp_ready);
            m_rdata      = s_rdata;
            m_rerr       = s_rerr;
        end else begin
            s_req_valid = 1'b0;
        end
    end

    assign grant = r_grant;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter (NCH=2); works with or without MEM_BUS_ARB_RR_EN.
module tb_mem_bus_arbiter;

    localparam int NCH = 2;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int MW  = DW / 8;

    logic                clk = 1'b0;
    logic                rstn;
    logic [NCH-1:0]      m_req_valid, m_req_ready, m_wen, m_resp_valid, m_resp_ready;
    logic [NCH*AW-1:0]   m_addr;
    logic [NCH*DW-1:0]   m_wdata;
    logic [NCH*MW-1:0]   m_wmask;
    logic [DW-1:0]       m_rdata, s_wdata, s_rdata;
    logic                m_rerr, s_req_valid, s_req_ready, s_wen, s_resp_valid, s_resp_ready, s_rerr;
    logic [AW-1:0]       s_addr;
    logic [MW-1:0]       s_wmask;
    logic [NCH-1:0]      grant;

    int errors = 0;
    int checks = 0;
    int ptr    = 0;

    mem_bus_arbiter #(.NCH(NCH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rstn(rstn),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
        .m_addr(m_addr), .m_wen(m_wen), .m_wdata(m_wdata), .m_wmask(m_wmask),
        .m_resp_valid(m_resp_valid), .m_resp_ready(m_resp_ready),
        .m_rdata(m_rdata), .m_rerr(m_rerr),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
        .s_addr(s_addr), .s_wen(s_wen), .s_wdata(s_wdata), .s_wmask(s_wmask),
        .s_resp_valid(s_resp_valid), .s_resp_ready(s_resp_ready),
        .s_rdata(s_rdata), .s_rerr(s_rerr), .grant(grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Reference arbitration: scan from the pointer (round-robin) or from channel 0 (fixed).
    function automatic int pick(input logic [NCH-1:0] v);
`ifdef MEM_BUS_ARB_RR_EN
        for (int k = 0; k < NCH; k++) begin
            int c;
            c = (ptr + k) % NCH;
            if (v[c]) return c;
        end
`else
        for (int i = 0; i < NCH; i++) begin
            if (v[i]) return i;
        end
`endif
        return -1;
    endfunction

    task automatic set_req(input int ch, input logic [31:0] a, input logic w,
                           input logic [31:0] d, input logic [3:0] m);
        m_req_valid[ch]         = 1'b1;
        m_addr[ch*AW +: AW]     = a;
        m_wen[ch]               = w;
        m_wdata[ch*DW +: DW]    = d;
        m_wmask[ch*MW +: MW]    = m;
    endtask

    task automatic chk_fields(input string tag, input int g);
        chk({tag, "_saddr"},  s_addr,  m_addr[g*AW +: AW]);
        chk({tag, "_swen"},   s_wen,   m_wen[g]);
        chk({tag, "_swdata"}, s_wdata, m_wdata[g*DW +: DW]);
        chk({tag, "_swmask"}, s_wmask, m_wmask[g*MW +: MW]);
    endtask

    // One full transaction starting in an IDLE cycle with at least one pending request.
    task automatic run_one(input int req_dly, input int rsp_dly, input int rr_dly,
                           input logic [31:0] rd, input logic re, input bit keep, output int g);
        logic [NCH-1:0] gm;
        #1;
        chk("idle_grant", grant, 0);
        chk("idle_sreq", s_req_valid, 0);
        chk("idle_mresp", m_resp_valid, 0);
        g  = pick(m_req_valid);
        gm = '0;
        gm[g] = 1'b1;
        nxt();
        for (int d = 0; d < req_dly; d++) begin
            s_req_ready = 1'b0;
            #1;
            chk("bp_grant", grant, gm);
            chk("bp_sreq", s_req_valid, 1);
            chk("bp_mready", m_req_ready, 0);
            chk_fields("bp", g);
            nxt();
        end
        s_req_ready = 1'b1;
        #1;
        chk("req_grant", grant, gm);
        chk("req_sreq", s_req_valid, 1);
        chk("req_mready", m_req_ready, gm);
        chk_fields("req", g);
        nxt();
        s_req_ready = 1'b0;
        if (!keep) m_req_valid[g] = 1'b0;
        for (int d = 0; d < rsp_dly; d++) begin
            #1;
            chk("wait_sreq", s_req_valid, 0);
            chk("wait_mresp", m_resp_valid, 0);
            chk("wait_grant", grant, gm);
            nxt();
        end
        s_resp_valid = 1'b1;
        s_rdata      = rd;
        s_rerr       = re;
        m_resp_ready = ~gm;
        for (int d = 0; d < rr_dly; d++) begin
            #1;
            chk("rbp_mresp", m_resp_valid, gm);
            chk("rbp_sready", s_resp_ready, 0);
            chk("rbp_grant", grant, gm);
            nxt();
        end
        m_resp_ready = '1;
        #1;
        chk("resp_mresp", m_resp_valid, gm);
        chk("resp_sready", s_resp_ready, 1);
        chk("resp_rdata", m_rdata, rd);
        chk("resp_rerr", m_rerr, re);
        nxt();
        s_resp_valid = 1'b0;
        m_resp_ready = '0;
        s_rdata      = $urandom;
        s_rerr       = 1'b0;
        ptr          = (g + 1) % NCH;
    endtask

    initial begin
        int g;
        int exp_order [4];
        rstn         = 1'b0;
        m_req_valid  = '1;
        m_addr       = {32'h0000_1000, 32'h0000_0100};
        m_wen        = '0;
        m_wdata      = '0;
        m_wmask      = '0;
        m_resp_ready = '0;
        s_req_ready  = 1'b0;
        s_resp_valid = 1'b0;
        s_rdata      = 32'h0;
        s_rerr       = 1'b0;

        // Reset held three cycles with every master requesting.
        repeat (3) nxt();
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_mready", m_req_ready, 0);
        chk("rst_mresp", m_resp_valid, 0);
        chk("rst_sreq", s_req_valid, 0);
        chk("rst_sready", s_resp_ready, 0);
        chk("rst_saddr", s_addr, 0);
        chk("rst_rdata", m_rdata, 0);
        rstn = 1'b1;
        run_one(0, 0, 0, 32'h0BAD_F00D, 1'b0, 1'b0, g);
        chk("rst_first_ch", g, 0);
        m_req_valid = '0;

        // Single read on channel 1 with a three-cycle slave delay.
        set_req(1, 32'h8000_0004, 1'b0, 32'h0, 4'h0);
        run_one(0, 3, 0, 32'hDEAD_BEEF, 1'b0, 1'b0, g);
        chk("single_ch", g, 1);

        // Contention: both channels keep requesting for four transactions.
        set_req(0, 32'h0000_2000, 1'b0, 32'h0, 4'h0);
        set_req(1, 32'h0000_3000, 1'b1, 32'hCAFE_0001, 4'hF);
`ifdef MEM_BUS_ARB_RR_EN
        exp_order = '{0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 0};
`endif
        for (int t = 0; t < 4; t++) begin
            run_one(0, 0, 0, $urandom, 1'b0, 1'b1, g);
            chk("cont_order", g, exp_order[t]);
        end
        m_req_valid = '0;

        // Backpressure on both the request and the response side.
        set_req(1, 32'h4000_0040, 1'b0, 32'h0, 4'h0);
        run_one(4, 0, 2, 32'h5555_AAAA, 1'b0, 1'b0, g);
        chk("bp_ch", g, 1);

        // Write with slave error on channel 0.
        set_req(0, 32'h1000_0000, 1'b1, 32'h1234_5678, 4'b0011);
        run_one(0, 0, 0, $urandom, 1'b1, 1'b0, g);
        chk("werr_ch", g, 0);

        // Reset during RESP drops the response; a fresh request then completes.
        set_req(0, 32'h2000_0000, 1'b0, 32'h0, 4'h0);
        nxt();
        s_req_ready = 1'b1;
        nxt();
        s_req_ready    = 1'b0;
        m_req_valid    = '0;
        s_resp_valid   = 1'b1;
        m_resp_ready   = '1;
        rstn           = 1'b0;
        nxt();
        #1;
        chk("abort_grant", grant, 0);
        chk("abort_mresp", m_resp_valid, 0);
        chk("abort_sready", s_resp_ready, 0);
        rstn         = 1'b1;
        s_resp_valid = 1'b0;
        m_resp_ready = '0;
        ptr          = 0;
        set_req(1, 32'h3000_0008, 1'b0, 32'h0, 4'h0);
        run_one(0, 1, 0, 32'h7777_0001, 1'b0, 1'b0, g);
        chk("abort_fresh_ch", g, 1);

        // Randomized traffic against the reference arbitration model.
        for (int t = 0; t < 40; t++) begin
            for (int c = 0; c < NCH; c++) begin
                if (!m_req_valid[c] && ($urandom_range(0, 1) == 1)) begin
                    set_req(c, $urandom, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));
                end
            end
            if (m_req_valid == '0) begin
                set_req($urandom_range(0, NCH - 1), $urandom, 1'b0, $urandom, 4'hF);
            end
            run_one($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom, 1'($urandom_range(0, 1)), 1'b0, g);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
